// File: rtl/seg7_cnt_display.sv
// Two-digit multiplexed 7-segment driver for a 6-bit count (0..63).
// Latency: 9 cycles from a cnt change to the new digit on seg (detect, 6 shifts, load, output register).
// No backpressure: cnt changes seen while busy are picked up once the current conversion finishes.
//
// Ports:
//   clk      system clock, all state on rising edge
//   rst      asynchronous active-high reset
//   cnt      binary value to display (0..63)
//   disp_en  1 = drive digits, 0 = all anodes off (timing keeps running)
//   seg      cathodes {g,f,e,d,c,b,a}, active-low, registered
//   dp       decimal point, active-low, registered, always off
//   an       anodes, active-low, registered, an[0] = rightmost digit
//   busy     high while a binary-to-BCD conversion is running
module seg7_cnt_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] cnt,
    input  logic       disp_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       busy
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [5:0]    last_cnt;
    logic [5:0]    cap;       // value under conversion, kept intact for last_cnt
    logic [5:0]    bin;       // binary half of the double-dabble shift register
    logic [3:0]    bcd_t;
    logic [3:0]    bcd_o;
    logic [3:0]    adj_t;
    logic [3:0]    adj_o;
    logic [2:0]    iter;
    logic [3:0]    tens;
    logic [3:0]    ones;

    logic [PW-1:0] presc;
    logic [1:0]    slot;

    logic [3:0]    an_d;
    logic [6:0]    seg_d;

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] s;
        s = 7'b1111111;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cnt != last_cnt) state_nxt = SHIFT;
            SHIFT:   if (iter == 3'd5) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Double-dabble correction: a nibble >= 5 would overflow past 9 when doubled.
    always_comb begin
        adj_t = (bcd_t >= 4'd5) ? bcd_t + 4'd3 : bcd_t;
        adj_o = (bcd_o >= 4'd5) ? bcd_o + 4'd3 : bcd_o;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_cnt <= 6'd0;
            cap      <= 6'd0;
            bin      <= 6'd0;
            bcd_t    <= 4'd0;
            bcd_o    <= 4'd0;
            iter     <= 3'd0;
            tens     <= 4'd0;
            ones     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cnt != last_cnt) begin
                        cap   <= cnt;
                        bin   <= cnt;
                        bcd_t <= 4'd0;
                        bcd_o <= 4'd0;
                        iter  <= 3'd0;
                    end
                end
                SHIFT: begin
                    {bcd_t, bcd_o, bin} <= {adj_t, adj_o, bin} << 1;
                    iter                <= iter + 3'd1;
                end
                DONE: begin
                    tens     <= bcd_t;
                    ones     <= bcd_o;
                    last_cnt <= cap;
                end
                default: ;
            endcase
        end
    end

    // ---------------- refresh timing ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            slot  <= 2'd0;
        end else if (presc == PRESC_TC) begin
            presc <= '0;
            slot  <= slot + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Slots 2 and 3 stay dark so each digit always gets a 1/4 duty cycle.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        if (disp_en) begin
            case (slot)
                2'd0: begin
                    an_d  = 4'b1110;
                    seg_d = encode(ones);
                end
                2'd1: begin
                    if (tens != 4'd0) begin
                        an_d  = 4'b1101;
                        seg_d = encode(tens);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_cnt_display.sv
module tb_seg7_cnt_display;

    logic       clk;
    logic       rst;
    logic [5:0] cnt;
    logic       disp_en;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       busy;

    int tests;
    int fails;
    int edge_n;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    seg7_cnt_display #(.REFRESH_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .cnt     (cnt),
        .disp_en (disp_en),
        .seg     (seg),
        .dp      (dp),
        .an      (an),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; output after edge n shows slot ((n-1)/4)%4.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    function automatic int cur_slot();
        return ((edge_n - 1) / 4) % 4;
    endfunction

    function automatic logic [3:0] exp_an(input int s, input int t);
        if (s == 0) return 4'b1110;
        if (s == 1 && t != 0) return 4'b1101;
        return 4'b1111;
    endfunction

    function automatic logic [6:0] exp_seg(input int s, input int t, input int o);
        if (s == 0) return seg_tab[o];
        if (s == 1 && t != 0) return seg_tab[t];
        return 7'b1111111;
    endfunction

    task automatic test_reset();
        int s;
        rst = 1'b0; cnt = 6'd0; disp_en = 1'b1;
        #2 rst = 1'b1;
        #1;
        tests++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_vals: an=%b seg=%b dp=%b busy=%b, want 1111 1111111 1 0", an, seg, dp, busy);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            s = cur_slot();
            tests++;
            if (an !== exp_an(s, 0) || seg !== exp_seg(s, 0, 0) || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle cyc %0d: an=%b seg=%b busy=%b, want an=%b seg=%b busy=0",
                         i, an, seg, busy, exp_an(s, 0), exp_seg(s, 0, 0));
            end
        end
    endtask

    task automatic test_convert_42();
        logic [11:0] pat;
        int s;
        @(negedge clk);
        cnt = 6'd42;
        pat = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pat = {pat[10:0], busy};
        end
        tests++;
        if (pat !== 12'b111111100000) begin
            fails++;
            $display("FAIL busy_42: pattern %b, want 111111100000", pat);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s = cur_slot();
            tests++;
            if (an !== exp_an(s, 4) || seg !== exp_seg(s, 4, 2) || dp !== 1'b1) begin
                fails++;
                $display("FAIL disp_42 cyc %0d: an=%b seg=%b dp=%b, want an=%b seg=%b dp=1",
                         i, an, seg, dp, exp_an(s, 4), exp_seg(s, 4, 2));
            end
        end
    endtask

    task automatic test_63_then_9();
        logic [11:0] pat;
        int s;
        @(negedge clk);
        cnt = 6'd63;
        pat = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pat = {pat[10:0], busy};
        end
        tests++;
        if (pat !== 12'b111111100000) begin
            fails++;
            $display("FAIL busy_63: pattern %b, want 111111100000", pat);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s = cur_slot();
            tests++;
            if (an !== exp_an(s, 6) || seg !== exp_seg(s, 6, 3)) begin
                fails++;
                $display("FAIL disp_63 cyc %0d: an=%b seg=%b, want an=%b seg=%b",
                         i, an, seg, exp_an(s, 6), exp_seg(s, 6, 3));
            end
        end
        cnt = 6'd9;
        for (int i = 0; i < 12; i++) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s = cur_slot();
            tests++;
            if (an !== exp_an(s, 0) || seg !== exp_seg(s, 0, 9)) begin
                fails++;
                $display("FAIL disp_9 cyc %0d: an=%b seg=%b, want an=%b seg=%b",
                         i, an, seg, exp_an(s, 0), exp_seg(s, 0, 9));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pat;
        @(negedge clk);
        cnt = 6'd5;
        pat = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pat = {pat[14:0], busy};
            if (i == 2) cnt = 6'd9;
            if (i == 7) begin
                tests++;
                if (dut.ones !== 4'd5 || dut.tens !== 4'd0) begin
                    fails++;
                    $display("FAIL b2b_first: tens=%0d ones=%0d, want 0 5", dut.tens, dut.ones);
                end
            end
            if (i == 15) begin
                tests++;
                if (dut.ones !== 4'd9 || dut.tens !== 4'd0) begin
                    fails++;
                    $display("FAIL b2b_second: tens=%0d ones=%0d, want 0 9", dut.tens, dut.ones);
                end
            end
        end
        tests++;
        if (pat !== 16'b1111111011111110) begin
            fails++;
            $display("FAIL b2b_busy: pattern %b, want 1111111011111110", pat);
        end
    endtask

    task automatic test_disp_en();
        logic [19:0] pat;
        int s;
        @(negedge clk);
        disp_en = 1'b0;
        cnt = 6'd17;
        pat = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pat = {pat[18:0], busy};
            tests++;
            if (an !== 4'b1111) begin
                fails++;
                $display("FAIL dis_an cyc %0d: an=%b, want 1111", i, an);
            end
        end
        tests++;
        if (pat !== 20'b11111110000000000000) begin
            fails++;
            $display("FAIL dis_busy: pattern %b, want 11111110000000000000", pat);
        end
        disp_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s = cur_slot();
            tests++;
            if (an !== exp_an(s, 1) || seg !== exp_seg(s, 1, 7) || busy !== 1'b0) begin
                fails++;
                $display("FAIL en_17 cyc %0d: an=%b seg=%b busy=%b, want an=%b seg=%b busy=0",
                         i, an, seg, busy, exp_an(s, 1), exp_seg(s, 1, 7));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] pat;
        int s;
        @(negedge clk);
        cnt = 6'd42;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || busy !== 1'b0 ||
            dut.tens !== 4'd0 || dut.ones !== 4'd0) begin
            fails++;
            $display("FAIL mid_reset: an=%b seg=%b dp=%b busy=%b tens=%0d ones=%0d, want 1111 1111111 1 0 0 0",
                     an, seg, dp, busy, dut.tens, dut.ones);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        pat = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pat = {pat[10:0], busy};
        end
        tests++;
        if (pat !== 12'b111111100000) begin
            fails++;
            $display("FAIL mid_busy: pattern %b, want 111111100000", pat);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s = cur_slot();
            tests++;
            if (an !== exp_an(s, 4) || seg !== exp_seg(s, 4, 2)) begin
                fails++;
                $display("FAIL mid_disp cyc %0d: an=%b seg=%b, want an=%b seg=%b",
                         i, an, seg, exp_an(s, 4), exp_seg(s, 4, 2));
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_convert_42();
        test_63_then_9();
        test_back_to_back();
        test_disp_en();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
